// File: rtl/punc_control.sv
// rtl/punc_control.sv - PUnC LC3 multi-cycle control unit (fetch/decode/execute FSM)
module punc_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n_flag,
    input  logic        z_flag,
    input  logic        p_flag,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic        pc_ld,
    output logic        pc_data_sel,
    output logic        pc_add_sel,
    output logic        ir_ld,
    output logic [1:0]  mem_addr_sel,
    output logic        mem_w_en,
    output logic        store_ld,
    output logic [2:0]  rf_r_addr_0,
    output logic [2:0]  rf_r_addr_1,
    output logic [2:0]  rf_w_addr,
    output logic        rf_w_en,
    output logic [1:0]  rf_w_sel,
    output logic        a_sel,
    output logic        b_sel,
    output logic [1:0]  alu_sel,
    output logic        nzp_ld,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] MEM_PC    = 2'b00;
    localparam logic [1:0] MEM_ALU   = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;
    localparam logic [1:0] WSEL_PC   = 2'b00;
    localparam logic [1:0] WSEL_MEM  = 2'b01;
    localparam logic [1:0] WSEL_ALU  = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_AND   = 2'b01;
    localparam logic [1:0] ALU_NOT   = 2'b11;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  w_opcode;
    logic [2:0]  w_dr;
    logic [2:0]  w_base;

    // The datapath owns the PC reset value; ir[4:3] are don't-care for every opcode here.
    logic [17:0] w_unused;
    assign w_unused = {RESET_PC, ir[4:3]};

    assign w_opcode = ir[15:12];
    assign w_dr     = ir[11:9];
    assign w_base   = ir[8:6];

    // State register; reset forces INIT immediately, dropping any in-flight instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode; everything stays low while reset is held.
    always_comb begin
        w_next_state = r_state;
        pc_clr       = 1'b0;
        pc_inc       = 1'b0;
        pc_ld        = 1'b0;
        pc_data_sel  = 1'b0;
        pc_add_sel   = 1'b0;
        ir_ld        = 1'b0;
        mem_addr_sel = MEM_PC;
        mem_w_en     = 1'b0;
        store_ld     = 1'b0;
        rf_r_addr_0  = 3'd0;
        rf_r_addr_1  = 3'd0;
        rf_w_addr    = 3'd0;
        rf_w_en      = 1'b0;
        rf_w_sel     = WSEL_PC;
        a_sel        = 1'b0;
        b_sel        = 1'b0;
        alu_sel      = ALU_ADD;
        nzp_ld       = 1'b0;
        halted       = 1'b0;

        if (rst) begin
            case (r_state)
                S_INIT: begin
                    pc_clr       = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_FETCH: begin
                    mem_addr_sel = MEM_PC;
                    ir_ld        = 1'b1;
                    pc_inc       = 1'b1;
                    w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    w_next_state = (w_opcode == OP_HALT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    w_next_state = S_FETCH;
                    case (w_opcode)
                        OP_ADD, OP_AND: begin
                            a_sel       = 1'b1;
                            rf_r_addr_0 = w_base;
                            rf_r_addr_1 = ir[2:0];
                            b_sel       = ir[5];
                            alu_sel     = (w_opcode == OP_AND) ? ALU_AND : ALU_ADD;
                            rf_w_addr   = w_dr;
                            rf_w_sel    = WSEL_ALU;
                            rf_w_en     = 1'b1;
                            nzp_ld      = 1'b1;
                        end
                        OP_NOT: begin
                            a_sel       = 1'b1;
                            rf_r_addr_0 = w_base;
                            alu_sel     = ALU_NOT;
                            rf_w_addr   = w_dr;
                            rf_w_sel    = WSEL_ALU;
                            rf_w_en     = 1'b1;
                            nzp_ld      = 1'b1;
                        end
                        OP_BR: begin
                            pc_ld      = (ir[11] & n_flag) | (ir[10] & z_flag) | (ir[9] & p_flag);
                            pc_add_sel = 1'b1;
                        end
                        OP_JMP: begin
                            rf_r_addr_0 = w_base;
                            pc_data_sel = 1'b1;
                            pc_ld       = 1'b1;
                        end
                        OP_JSR: begin
                            // Link write and PC load share one edge, so JSRR R7 jumps to the old R7.
                            rf_w_addr = 3'd7;
                            rf_w_sel  = WSEL_PC;
                            rf_w_en   = 1'b1;
                            pc_ld     = 1'b1;
                            if (!ir[11]) begin
                                pc_data_sel = 1'b1;
                                rf_r_addr_0 = w_base;
                            end
                        end
                        OP_LD: begin
                            b_sel        = 1'b1;
                            mem_addr_sel = MEM_ALU;
                            rf_w_sel     = WSEL_MEM;
                            rf_w_addr    = w_dr;
                            rf_w_en      = 1'b1;
                            nzp_ld       = 1'b1;
                        end
                        OP_LDR: begin
                            a_sel        = 1'b1;
                            rf_r_addr_0  = w_base;
                            b_sel        = 1'b1;
                            mem_addr_sel = MEM_ALU;
                            rf_w_sel     = WSEL_MEM;
                            rf_w_addr    = w_dr;
                            rf_w_en      = 1'b1;
                            nzp_ld       = 1'b1;
                        end
                        OP_LEA: begin
                            b_sel     = 1'b1;
                            rf_w_sel  = WSEL_ALU;
                            rf_w_addr = w_dr;
                            rf_w_en   = 1'b1;
                        end
                        OP_ST: begin
                            b_sel        = 1'b1;
                            mem_addr_sel = MEM_ALU;
                            rf_r_addr_1  = w_dr;
                            mem_w_en     = 1'b1;
                        end
                        OP_STR: begin
                            a_sel        = 1'b1;
                            rf_r_addr_0  = w_base;
                            b_sel        = 1'b1;
                            mem_addr_sel = MEM_ALU;
                            rf_r_addr_1  = w_dr;
                            mem_w_en     = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            // First access fetches the pointer into the store register.
                            b_sel        = 1'b1;
                            mem_addr_sel = MEM_ALU;
                            store_ld     = 1'b1;
                            w_next_state = S_EXEC2;
                        end
                        default: begin
                        end
                    endcase
                end
                S_EXEC2: begin
                    mem_addr_sel = MEM_STORE;
                    w_next_state = S_FETCH;
                    if (w_opcode == OP_LDI) begin
                        rf_w_sel  = WSEL_MEM;
                        rf_w_addr = w_dr;
                        rf_w_en   = 1'b1;
                        nzp_ld    = 1'b1;
                    end else begin
                        rf_r_addr_1 = w_dr;
                        mem_w_en    = 1'b1;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    w_next_state = S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_punc_control.sv
// tb/tb_punc_control.sv - self-checking bench for punc_control
module tb_punc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        n_flag, z_flag, p_flag;
    logic        pc_clr, pc_inc, pc_ld, pc_data_sel, pc_add_sel, ir_ld;
    logic [1:0]  mem_addr_sel;
    logic        mem_w_en, store_ld;
    logic [2:0]  rf_r_addr_0, rf_r_addr_1, rf_w_addr;
    logic        rf_w_en;
    logic [1:0]  rf_w_sel;
    logic        a_sel, b_sel;
    logic [1:0]  alu_sel;
    logic        nzp_ld, halted;

    always #5 clk = ~clk;

    punc_control #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .ir(ir),
        .n_flag(n_flag), .z_flag(z_flag), .p_flag(p_flag),
        .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld(pc_ld),
        .pc_data_sel(pc_data_sel), .pc_add_sel(pc_add_sel), .ir_ld(ir_ld),
        .mem_addr_sel(mem_addr_sel), .mem_w_en(mem_w_en), .store_ld(store_ld),
        .rf_r_addr_0(rf_r_addr_0), .rf_r_addr_1(rf_r_addr_1), .rf_w_addr(rf_w_addr),
        .rf_w_en(rf_w_en), .rf_w_sel(rf_w_sel), .a_sel(a_sel), .b_sel(b_sel),
        .alu_sel(alu_sel), .nzp_ld(nzp_ld), .halted(halted)
    );

    typedef struct packed {
        logic       pc_clr;
        logic       pc_inc;
        logic       pc_ld;
        logic       pc_data_sel;
        logic       pc_add_sel;
        logic       ir_ld;
        logic [1:0] mem_addr_sel;
        logic       mem_w_en;
        logic       store_ld;
        logic [2:0] r0;
        logic [2:0] r1;
        logic [2:0] w_addr;
        logic       rf_w_en;
        logic [1:0] rf_w_sel;
        logic       a_sel;
        logic       b_sel;
        logic [1:0] alu_sel;
        logic       nzp_ld;
        logic       halted;
    } ctl_t;

    typedef struct {
        logic [15:0] ir;
        logic [2:0]  nzp;
        ctl_t        e_exec;
        ctl_t        e_exec2;
        string       tag;
    } vec_t;

    ctl_t act;
    assign act = {pc_clr, pc_inc, pc_ld, pc_data_sel, pc_add_sel, ir_ld, mem_addr_sel,
                  mem_w_en, store_ld, rf_r_addr_0, rf_r_addr_1, rf_w_addr, rf_w_en,
                  rf_w_sel, a_sel, b_sel, alu_sel, nzp_ld, halted};

    int checks = 0;
    int errors = 0;

    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_EXEC2 = 3, PH_HALT = 4, PH_INIT = 5;

    task automatic check(input string name, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_indirect(input logic [15:0] i);
        return (i[15:12] == 4'b1010) || (i[15:12] == 4'b1011);
    endfunction

    // Reference: what each instruction class must drive in each phase of its life.
    function automatic ctl_t model(input int phase, input logic [15:0] i, input logic n, input logic z, input logic p);
        ctl_t c;
        logic [3:0] op;
        bit ind, ld, st, based, pcrel, alu;
        c     = '0;
        op    = i[15:12];
        ind   = is_indirect(i);
        ld    = op inside {4'b0010, 4'b0110, 4'b1010};
        st    = op inside {4'b0011, 4'b0111, 4'b1011};
        based = op inside {4'b0110, 4'b0111};
        pcrel = op inside {4'b0010, 4'b0011, 4'b1010, 4'b1011, 4'b1110};
        alu   = op inside {4'b0001, 4'b0101, 4'b1001};
        if (phase == PH_INIT) c.pc_clr = 1'b1;
        if (phase == PH_FETCH) begin c.pc_inc = 1'b1; c.ir_ld = 1'b1; end
        if (phase == PH_HALT) c.halted = 1'b1;
        if (phase == PH_EXEC) begin
            if (pcrel) c.b_sel = 1'b1;
            if (based) begin c.a_sel = 1'b1; c.r0 = i[8:6]; c.b_sel = 1'b1; end
            if (ld || st) begin
                c.mem_addr_sel = 2'b01;
                if (ind) c.store_ld = 1'b1;
            end
            if (ld && !ind) begin c.rf_w_en = 1'b1; c.rf_w_sel = 2'b01; c.w_addr = i[11:9]; c.nzp_ld = 1'b1; end
            if (st && !ind) begin c.r1 = i[11:9]; c.mem_w_en = 1'b1; end
            if (op == 4'b1110) begin c.rf_w_en = 1'b1; c.rf_w_sel = 2'b10; c.w_addr = i[11:9]; end
            if (alu) begin
                c.a_sel = 1'b1; c.r0 = i[8:6];
                c.rf_w_en = 1'b1; c.rf_w_sel = 2'b10; c.w_addr = i[11:9]; c.nzp_ld = 1'b1;
                if (op == 4'b1001) c.alu_sel = 2'b11;
                else begin
                    c.r1 = i[2:0]; c.b_sel = i[5];
                    c.alu_sel = (op == 4'b0101) ? 2'b01 : 2'b00;
                end
            end
            if (op == 4'b0000) begin
                c.pc_add_sel = 1'b1;
                c.pc_ld = (i[11] && n) || (i[10] && z) || (i[9] && p);
            end
            if (op == 4'b1100) begin c.r0 = i[8:6]; c.pc_data_sel = 1'b1; c.pc_ld = 1'b1; end
            if (op == 4'b0100) begin
                c.w_addr = 3'd7; c.rf_w_en = 1'b1; c.pc_ld = 1'b1;
                if (!i[11]) begin c.pc_data_sel = 1'b1; c.r0 = i[8:6]; end
            end
        end
        if (phase == PH_EXEC2 && ind) begin
            c.mem_addr_sel = 2'b10;
            if (ld) begin c.rf_w_en = 1'b1; c.rf_w_sel = 2'b01; c.w_addr = i[11:9]; c.nzp_ld = 1'b1; end
            else begin c.r1 = i[11:9]; c.mem_w_en = 1'b1; end
        end
        return c;
    endfunction

    // Entered at the start of a FETCH cycle; returns at the start of the next FETCH.
    task automatic run_instr(input logic [15:0] i, input logic [2:0] f, input ctl_t e1, input ctl_t e2, input string tag);
        ctl_t fe;
        fe = '0; fe.pc_inc = 1'b1; fe.ir_ld = 1'b1;
        ir = i; {n_flag, z_flag, p_flag} = f;
        #1;
        check({tag, "_fetch"}, fe);
        step; check({tag, "_decode"}, '0);
        step; check({tag, "_exec"}, e1);
        if (is_indirect(i)) begin
            step; check({tag, "_exec2"}, e2);
        end
        step;
    endtask

    vec_t tbl[10];
    ctl_t e, e2, zero_c, init_c;

    initial begin
        zero_c = '0;
        init_c = '0; init_c.pc_clr = 1'b1;

        e = '0; e.r0 = 3'd2; e.r1 = 3'd5; e.a_sel = 1; e.b_sel = 1; e.alu_sel = 2'b00;
        e.w_addr = 3'd1; e.rf_w_sel = 2'b10; e.rf_w_en = 1; e.nzp_ld = 1;
        tbl[0] = '{16'h12A5, 3'b000, e, zero_c, "add_imm"};
        e = '0; e.pc_ld = 1; e.pc_add_sel = 1;
        tbl[1] = '{16'h0403, 3'b010, e, zero_c, "brz_taken"};
        e = '0; e.pc_add_sel = 1;
        tbl[2] = '{16'h0403, 3'b101, e, zero_c, "brz_not_taken"};
        e = '0; e.b_sel = 1; e.mem_addr_sel = 2'b01; e.store_ld = 1;
        e2 = '0; e2.mem_addr_sel = 2'b10; e2.rf_w_sel = 2'b01; e2.w_addr = 3'd3; e2.rf_w_en = 1; e2.nzp_ld = 1;
        tbl[3] = '{16'hA602, 3'b000, e, e2, "ldi"};
        e2 = '0; e2.mem_addr_sel = 2'b10; e2.r1 = 3'd3; e2.mem_w_en = 1;
        tbl[4] = '{16'hB602, 3'b000, e, e2, "sti"};
        e = '0; e.rf_w_en = 1; e.w_addr = 3'd7; e.rf_w_sel = 2'b00; e.pc_ld = 1; e.pc_data_sel = 1; e.r0 = 3'd7;
        tbl[5] = '{16'h41C0, 3'b000, e, zero_c, "jsrr_r7"};
        e = '0; e.rf_w_en = 1; e.w_addr = 3'd7; e.pc_ld = 1;
        tbl[6] = '{16'h4805, 3'b000, e, zero_c, "jsr"};
        tbl[7] = '{16'h8FFF, 3'b111, zero_c, zero_c, "nop_1000"};
        e = '0; e.a_sel = 1; e.alu_sel = 2'b11; e.r0 = 3'd1; e.w_addr = 3'd3; e.rf_w_sel = 2'b10; e.rf_w_en = 1; e.nzp_ld = 1;
        tbl[8] = '{16'h967F, 3'b000, e, zero_c, "not"};
        e = '0; e.b_sel = 1; e.rf_w_sel = 2'b10; e.w_addr = 3'd6; e.rf_w_en = 1;
        tbl[9] = '{16'hEC05, 3'b000, e, zero_c, "lea"};

        rst = 1'b0; ir = 16'h0000; {n_flag, z_flag, p_flag} = 3'b000;
        step; step;
        check("reset_hold", zero_c);
        rst = 1'b1; #1;
        check("init", init_c);
        step;

        foreach (tbl[k]) run_instr(tbl[k].ir, tbl[k].nzp, tbl[k].e_exec, tbl[k].e_exec2, tbl[k].tag);

        for (int k = 0; k < 150; k++) begin
            logic [15:0] ri;
            logic [2:0]  rf;
            ri = 16'($urandom);
            ri[15:12] = 4'($urandom_range(0, 14));
            rf = 3'($urandom);
            run_instr(ri, rf, model(PH_EXEC, ri, rf[2], rf[1], rf[0]),
                      model(PH_EXEC2, ri, rf[2], rf[1], rf[0]), "rand");
        end

        // HALT parks the FSM regardless of ir changes.
        ir = 16'hF025; #1;
        check("halt_fetch", model(PH_FETCH, ir, 1'b0, 1'b0, 1'b0));
        step; check("halt_decode", zero_c);
        for (int k = 0; k < 12; k++) begin
            step;
            ir = 16'($urandom);
            #1;
            check("halted", model(PH_HALT, ir, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0; #1;
        check("halt_reset", zero_c);
        step; rst = 1'b1; #1;
        check("halt_reinit", init_c);
        step;

        // Reset asserted in the middle of STI's EXEC2 kills the store at once.
        ir = 16'hB602; #1;
        step; step; step;
        check("sti_exec2_pre", tbl[4].e_exec2);
        #2; rst = 1'b0; #1;
        check("sti_async_rst", zero_c);
        step; check("sti_rst_held", zero_c);
        rst = 1'b1; #1;
        check("sti_reinit", init_c);
        step;
        run_instr(tbl[0].ir, tbl[0].nzp, tbl[0].e_exec, tbl[0].e_exec2, "post_rst_add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
